// File: rtl/gf_interp_pkg.sv
// Shared constants and types for the interpolator output path.
// Frame length, index width and serializer state encoding live here.
package gf_interp_pkg;

    localparam int INTERP_RATIO = 10;
    localparam int IDX_W        = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } serializer_state_t;

endpackage

// File: rtl/interp_serializer_10x.sv
// Double-buffered 10:1 serializer: a shadow bank accepts the next frame while
// the active bank is shifted out one sample per clk_en_10x tick.
module interp_serializer_10x
    import gf_interp_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] INIT_VALUE = 8'h80
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en_10x,
    input  logic             load,
    input  logic [WIDTH-1:0] sample_y0,
    input  logic [WIDTH-1:0] sample_y1,
    input  logic [WIDTH-1:0] sample_y2,
    input  logic [WIDTH-1:0] sample_y3,
    input  logic [WIDTH-1:0] sample_y4,
    input  logic [WIDTH-1:0] sample_y5,
    input  logic [WIDTH-1:0] sample_y6,
    input  logic [WIDTH-1:0] sample_y7,
    input  logic [WIDTH-1:0] sample_y8,
    input  logic [WIDTH-1:0] sample_y9,
    input  logic             clear_flags,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_valid,
    output logic             frame_start,
    output logic             underrun,
    output logic             overrun
);

    logic [WIDTH-1:0]  frame_in [INTERP_RATIO];
    logic [WIDTH-1:0]  shadow_q [INTERP_RATIO];
    logic [WIDTH-1:0]  active_q [INTERP_RATIO];

    serializer_state_t state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              shadow_full_q, shadow_full_d;
    logic [WIDTH-1:0]  sample_out_q, sample_out_d;
    logic              sample_valid_q, sample_valid_d;
    logic              frame_start_q, frame_start_d;
    logic              underrun_q, underrun_d;
    logic              overrun_q, overrun_d;

    logic tick_load, transfer, set_underrun, set_overrun;

    assign frame_in[0] = sample_y0;
    assign frame_in[1] = sample_y1;
    assign frame_in[2] = sample_y2;
    assign frame_in[3] = sample_y3;
    assign frame_in[4] = sample_y4;
    assign frame_in[5] = sample_y5;
    assign frame_in[6] = sample_y6;
    assign frame_in[7] = sample_y7;
    assign frame_in[8] = sample_y8;
    assign frame_in[9] = sample_y9;

    assign tick_load    = clk_en_10x && load;
    assign transfer     = clk_en_10x && shadow_full_q && ((state_q == IDLE) || (idx_q == '0));
    // A load coinciding with a transfer refills the bank just emptied, so it is not an overrun.
    assign set_overrun  = tick_load && shadow_full_q && !transfer;
    assign set_underrun = clk_en_10x && (state_q == RUN) && (idx_q == '0) && !shadow_full_q;

    // Banks carry no reset: their contents are only observed after a load/transfer.
    always_ff @(posedge clk) begin
        for (int i = 0; i < INTERP_RATIO; i++) begin
            if (tick_load) shadow_q[i] <= frame_in[i];
            if (transfer)  active_q[i] <= shadow_q[i];
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        shadow_full_d  = shadow_full_q;
        sample_out_d   = sample_out_q;
        sample_valid_d = sample_valid_q;
        frame_start_d  = frame_start_q;
        if (clk_en_10x) begin
            shadow_full_d = load | (shadow_full_q & ~transfer);
            if (transfer) begin
                state_d        = RUN;
                idx_d          = IDX_W'(1);
                sample_out_d   = shadow_q[0];
                sample_valid_d = 1'b1;
                frame_start_d  = 1'b1;
            end else if ((state_q == RUN) && (idx_q != '0)) begin
                sample_out_d   = active_q[idx_q];
                idx_d          = (idx_q == IDX_W'(INTERP_RATIO - 1)) ? '0 : idx_q + IDX_W'(1);
                sample_valid_d = 1'b1;
                frame_start_d  = 1'b0;
            end else begin
                state_d        = IDLE;
                sample_valid_d = 1'b0;
                frame_start_d  = 1'b0;
            end
        end
        underrun_d = set_underrun | (underrun_q & ~clear_flags);
        overrun_d  = set_overrun  | (overrun_q  & ~clear_flags);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            shadow_full_q  <= 1'b0;
            sample_out_q   <= INIT_VALUE;
            sample_valid_q <= 1'b0;
            frame_start_q  <= 1'b0;
            underrun_q     <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            shadow_full_q  <= shadow_full_d;
            sample_out_q   <= sample_out_d;
            sample_valid_q <= sample_valid_d;
            frame_start_q  <= frame_start_d;
            underrun_q     <= underrun_d;
            overrun_q      <= overrun_d;
        end
    end

    assign sample_out   = sample_out_q;
    assign sample_valid = sample_valid_q;
    assign frame_start  = frame_start_q;
    assign underrun     = underrun_q;
    assign overrun      = overrun_q;

endmodule
